wd_session_ctrl: RTL and testbench

Watchdog session controller that sits directly downstream of the 100 ms timer chain. It consumes the 100 ms timeout pulse, drives that chain's count enable, and counts 100 ms ticks toward a session timeout. A kick from user activity reloads the session. The block raises a warning window before expiry, then signals expiry to the access/lock logic.

---
 rtl/wd_session_ctrl.sv | 141 ++++++++++++++
 tb/tb_wd_session_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wd_session_ctrl.sv
// Watchdog session controller: counts 100 ms ticks from arm/kick toward expiry, with a warning window.
// Optional macro WDSESS_AUTORELOAD_EN: EXPIRED lasts one cycle, then the session re-arms automatically.
module wd_session_ctrl #(
  parameter int TIMEOUT_TICKS = 50,
  parameter int WARN_TICKS    = 20,
  parameter int CNT_W         = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick_100ms,
  input  logic             i_arm,
  input  logic             i_kick,
  input  logic             i_disarm,
  output logic             o_count_en,
  output logic             o_warn,
  output logic             o_expired,
  output logic             o_expire_pulse,
  output logic [CNT_W-1:0] o_remaining
);

  // state     | meaning
  // S_IDLE    | no session, timer chain stopped
  // S_ARMED   | session running, above the warning threshold
  // S_WARN    | session running, inside the warning window
  // S_EXPIRED | session timed out, waiting for disarm (or auto re-arm)
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_WARN    = 3'd2,
    S_EXPIRED = 3'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] LP_WARN    = CNT_W'(WARN_TICKS);
  localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_remaining;
  logic             r_count_en;
  logic             r_warn;
  logic             r_expired;
  logic             r_expire_pulse;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_remaining_nxt;
  logic [CNT_W-1:0] w_dec;
  logic             w_reload_kick;

  assign w_dec = r_remaining - LP_ONE;

  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_reload_kick   = 1'b0;
    case (r_state)
      S_IDLE: begin
        // kick outranks arm even though IDLE ignores it, so kick+arm does not start a session
        if (i_arm && !i_disarm && !i_kick) begin
          w_state_nxt     = S_ARMED;
          w_remaining_nxt = LP_TIMEOUT;
        end
      end
      S_ARMED: begin
        if (i_disarm) begin
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = '0;
        end else if (i_kick) begin
          w_remaining_nxt = LP_TIMEOUT;
          w_reload_kick   = 1'b1;
        end else if (i_arm) begin
          w_state_nxt = S_ARMED;
        end else if (i_tick_100ms) begin
          w_remaining_nxt = w_dec;
          if (w_dec == LP_WARN) w_state_nxt = S_WARN;
        end
      end
      S_WARN: begin
        if (i_disarm) begin
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = '0;
        end else if (i_kick) begin
          w_state_nxt     = S_ARMED;
          w_remaining_nxt = LP_TIMEOUT;
          w_reload_kick   = 1'b1;
        end else if (i_arm) begin
          w_state_nxt = S_WARN;
        end else if (i_tick_100ms) begin
          if (r_remaining == LP_ONE) begin
            w_state_nxt     = S_EXPIRED;
            w_remaining_nxt = '0;
          end else begin
            w_remaining_nxt = w_dec;
          end
        end
      end
      S_EXPIRED: begin
        if (i_disarm) begin
          w_state_nxt     = S_IDLE;
          w_remaining_nxt = '0;
        end else begin
`ifdef WDSESS_AUTORELOAD_EN
          w_state_nxt     = S_ARMED;
          w_remaining_nxt = LP_TIMEOUT;
`else
          w_state_nxt     = S_EXPIRED;
`endif
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_remaining_nxt = '0;
      end
    endcase
  end

  // Outputs are registered from the next state; a kick holds count_en low for one cycle to restart the chain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_remaining    <= '0;
      r_count_en     <= 1'b0;
      r_warn         <= 1'b0;
      r_expired      <= 1'b0;
      r_expire_pulse <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_remaining    <= w_remaining_nxt;
      r_count_en     <= ((w_state_nxt == S_ARMED) || (w_state_nxt == S_WARN)) && !w_reload_kick;
      r_warn         <= (w_state_nxt == S_WARN);
      r_expired      <= (w_state_nxt == S_EXPIRED);
      r_expire_pulse <= (w_state_nxt == S_EXPIRED) && (r_state != S_EXPIRED);
    end
  end

  assign o_count_en     = r_count_en;
  assign o_warn         = r_warn;
  assign o_expired      = r_expired;
  assign o_expire_pulse = r_expire_pulse;
  assign o_remaining    = r_remaining;

endmodule

// File: tb/tb_wd_session_ctrl.sv
// Directed, table-driven bench for wd_session_ctrl with TIMEOUT_TICKS=5, WARN_TICKS=2, CNT_W=4.
// Define WDSESS_AUTORELOAD_EN for both files to exercise the auto re-arm build.
module tb_wd_session_ctrl;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       arm;
  logic       kick;
  logic       disarm;
  logic       count_en;
  logic       warn;
  logic       expired;
  logic       expire_pulse;
  logic [3:0] remaining;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string name;
    bit    arm;
    bit    kick;
    bit    disarm;
    bit    tick;
    bit    ce;
    bit    warn;
    bit    expired;
    bit    pulse;
    int    rem;
  } vec_t;

  vec_t vecs[$];

  wd_session_ctrl #(
    .TIMEOUT_TICKS(5),
    .WARN_TICKS   (2),
    .CNT_W        (4)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_tick_100ms  (tick),
    .i_arm         (arm),
    .i_kick        (kick),
    .i_disarm      (disarm),
    .o_count_en    (count_en),
    .o_warn        (warn),
    .o_expired     (expired),
    .o_expire_pulse(expire_pulse),
    .o_remaining   (remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic add(input string name, input bit a, input bit k, input bit d, input bit t,
                     input bit ce, input bit w, input bit e, input bit p, input int rem);
    vec_t v;
    v.name = name; v.arm = a; v.kick = k; v.disarm = d; v.tick = t;
    v.ce = ce; v.warn = w; v.expired = e; v.pulse = p; v.rem = rem;
    vecs.push_back(v);
  endtask

  task automatic check_all(input string name, input bit ce, input bit w, input bit e,
                           input bit p, input int rem);
    check({name, ".count_en"}, int'(count_en), int'(ce));
    check({name, ".warn"}, int'(warn), int'(w));
    check({name, ".expired"}, int'(expired), int'(e));
    check({name, ".expire_pulse"}, int'(expire_pulse), int'(p));
    check({name, ".remaining"}, int'(remaining), rem);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; arm = 1'b0; kick = 1'b0; disarm = 1'b0;

    //              name          arm kick dis tick | ce w  e  p  rem
    add("basic_arm",     1, 0, 0, 0,  1, 0, 0, 0, 5);
    add("basic_t1",      0, 0, 0, 1,  1, 0, 0, 0, 4);
    add("basic_gap",     0, 0, 0, 0,  1, 0, 0, 0, 4);
    add("basic_t2",      0, 0, 0, 1,  1, 0, 0, 0, 3);
    add("basic_t3",      0, 0, 0, 1,  1, 1, 0, 0, 2);
    add("basic_t4",      0, 0, 0, 1,  1, 1, 0, 0, 1);
    add("basic_t5",      0, 0, 0, 1,  0, 0, 1, 1, 0);
`ifdef WDSESS_AUTORELOAD_EN
    add("auto_rearm",    0, 0, 0, 0,  1, 0, 0, 0, 5);
    add("auto_t1",       0, 0, 0, 1,  1, 0, 0, 0, 4);
    add("auto_t2",       0, 0, 0, 1,  1, 0, 0, 0, 3);
    add("auto_t3",       0, 0, 0, 1,  1, 1, 0, 0, 2);
    add("auto_t4",       0, 0, 0, 1,  1, 1, 0, 0, 1);
    add("auto_t5",       0, 0, 0, 1,  0, 0, 1, 1, 0);
    add("auto_rearm2",   0, 0, 0, 0,  1, 0, 0, 0, 5);
    add("auto_t6",       0, 0, 0, 1,  1, 0, 0, 0, 4);
    add("auto_t7",       0, 0, 0, 1,  1, 0, 0, 0, 3);
    add("auto_t8",       0, 0, 0, 1,  1, 1, 0, 0, 2);
    add("auto_t9",       0, 0, 0, 1,  1, 1, 0, 0, 1);
    add("auto_t10",      0, 0, 0, 1,  0, 0, 1, 1, 0);
    add("auto_disarm",   0, 0, 1, 0,  0, 0, 0, 0, 0);
`else
    add("basic_hold",    0, 0, 0, 0,  0, 0, 1, 0, 0);
    add("sticky_kick",   0, 1, 0, 0,  0, 0, 1, 0, 0);
    add("sticky_arm",    1, 0, 0, 0,  0, 0, 1, 0, 0);
    add("sticky_t1",     0, 0, 0, 1,  0, 0, 1, 0, 0);
    add("sticky_t2",     0, 0, 0, 1,  0, 0, 1, 0, 0);
    add("sticky_t3",     0, 0, 0, 1,  0, 0, 1, 0, 0);
    add("sticky_disarm", 0, 0, 1, 0,  0, 0, 0, 0, 0);
`endif
    add("kw_arm",        1, 0, 0, 0,  1, 0, 0, 0, 5);
    add("kw_t1",         0, 0, 0, 1,  1, 0, 0, 0, 4);
    add("kw_t2",         0, 0, 0, 1,  1, 0, 0, 0, 3);
    add("kw_t3",         0, 0, 0, 1,  1, 1, 0, 0, 2);
    add("kw_kick",       0, 1, 0, 0,  0, 0, 0, 0, 5);
    add("kw_after",      0, 0, 0, 0,  1, 0, 0, 0, 5);
    add("kw_t4",         0, 0, 0, 1,  1, 0, 0, 0, 4);
    add("kw_t5",         0, 0, 0, 1,  1, 0, 0, 0, 3);
    add("kw_t6",         0, 0, 0, 1,  1, 1, 0, 0, 2);
    add("kw_t7",         0, 0, 0, 1,  1, 1, 0, 0, 1);
    add("kw_t8",         0, 0, 0, 1,  0, 0, 1, 1, 0);
    add("kw_disarm",     0, 0, 1, 0,  0, 0, 0, 0, 0);
    add("sim_arm",       1, 0, 0, 0,  1, 0, 0, 0, 5);
    add("sim_t1",        0, 0, 0, 1,  1, 0, 0, 0, 4);
    add("sim_t2",        0, 0, 0, 1,  1, 0, 0, 0, 3);
    add("sim_kick_tick", 0, 1, 0, 1,  0, 0, 0, 0, 5);
    add("sim_after",     0, 0, 0, 0,  1, 0, 0, 0, 5);
    add("sim_dis_kick",  0, 1, 1, 0,  0, 0, 0, 0, 0);
    add("idle_kick_arm", 1, 1, 0, 0,  0, 0, 0, 0, 0);
    add("idle_arm_tick", 1, 0, 0, 1,  1, 0, 0, 0, 5);
    add("wd_t1",         0, 0, 0, 1,  1, 0, 0, 0, 4);
    add("wd_t2",         0, 0, 0, 1,  1, 0, 0, 0, 3);
    add("wd_t3",         0, 0, 0, 1,  1, 1, 0, 0, 2);
    add("wd_dis_tick",   0, 0, 1, 1,  0, 0, 0, 0, 0);

    // reset held, then released: everything idle
    repeat (2) @(negedge clk);
    check_all("reset", 0, 0, 0, 0, 0);
    rst = 1'b0;

    // start a session, then hit reset between clock edges
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check("pre_rst.count_en", int'(count_en), 1);
    check("pre_rst.remaining", int'(remaining), 4);
    #2 rst = 1'b1;
    #1 check_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0; tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ticks.count_en", int'(count_en), 0);
      check("idle_ticks.remaining", int'(remaining), 0);
    end
    tick = 1'b0;

    foreach (vecs[i]) begin
      arm = vecs[i].arm; kick = vecs[i].kick; disarm = vecs[i].disarm; tick = vecs[i].tick;
      @(negedge clk);
      check_all(vecs[i].name, vecs[i].ce, vecs[i].warn, vecs[i].expired, vecs[i].pulse, vecs[i].rem);
    end
    arm = 1'b0; kick = 1'b0; disarm = 1'b0; tick = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
